// File: rtl/touch_panel_scan_ctrl.sv
// Avalon-MM touch-panel scan controller for an ADS7843-class resistive touch ADC.
// On pen-down, runs X then Y 12-bit conversions and publishes both results together.
module touch_panel_scan_ctrl #(
    parameter int unsigned CLK_DIV       = 16,
    parameter int unsigned SETTLE_CYCLES = 5000,
    parameter logic [7:0]  CMD_X         = 8'h90,
    parameter logic [7:0]  CMD_Y         = 8'hD0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        pen_irq_n,
    output logic        adc_cs_n,
    output logic        adc_dclk,
    output logic        adc_din,
    input  logic        adc_dout
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONV_X,
        CONV_Y,
        HOLD
    } state_t;

    state_t            state;
    logic [SET_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        bit_idx;
    logic [11:0]       shreg;
    logic [11:0]       x_tmp;
    logic [11:0]       x_reg;
    logic [11:0]       y_reg;

    logic              sync1, sync2, sync3;
    logic              pen_down;
    logic              pen_edge;

    logic              enable;
    logic              continuous;
    logic [2:0]        irq_mask;
    logic [2:0]        evt;

    logic              wr;
    logic              ctrl_wr;
    logic              mask_wr;
    logic              evt_wr;
    logic              enable_eff;
    logic              period_end;
    logic              conv_done;
    logic              release_up;
    logic              busy;
    logic [2:0]        evt_set;
    logic [2:0]        evt_clr;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign unused_wdata = ^writedata[31:3];

    function automatic logic cmd_bit(input logic [7:0] cmd, input logic [4:0] idx);
        if (idx < 5'd8) begin
            return cmd[3'd7 - idx[2:0]];
        end
        return 1'b0;
    endfunction

    // Synchronizer resets to the released level so reset never fakes a pen-down edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= pen_irq_n;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign pen_down = ~sync2;
    assign pen_edge = sync3 & ~sync2;

    assign wr         = chipselect & ~write_n;
    assign ctrl_wr    = wr && (address == 3'd0);
    assign mask_wr    = wr && (address == 3'd3);
    assign evt_wr     = wr && (address == 3'd4);
    // A CTRL write takes effect on the FSM in the same edge it lands.
    assign enable_eff = ctrl_wr ? writedata[0] : enable;
    assign busy       = (state != IDLE);

    assign period_end = (div_cnt == DIV_LAST) && adc_dclk;
    assign conv_done  = (state == CONV_Y) && period_end && (bit_idx == 5'd23) && enable_eff;
    assign release_up = (state == HOLD) && (cnt == '0) && !pen_down && enable_eff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            x_tmp    <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            adc_cs_n <= 1'b1;
            adc_dclk <= 1'b0;
            adc_din  <= 1'b0;
        end else if (busy && !enable_eff) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_idx  <= '0;
            adc_cs_n <= 1'b1;
            adc_dclk <= 1'b0;
            adc_din  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_eff && pen_down) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state    <= CONV_X;
                        div_cnt  <= '0;
                        bit_idx  <= '0;
                        adc_cs_n <= 1'b0;
                        adc_dclk <= 1'b0;
                        adc_din  <= CMD_X[7];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CONV_X, CONV_Y: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!adc_dclk) begin
                            adc_dclk <= 1'b1;
                            // Rising edges 10..21 carry D11..D0.
                            if (bit_idx >= 5'd9 && bit_idx <= 5'd20) begin
                                shreg <= {shreg[10:0], adc_dout};
                            end
                        end else begin
                            adc_dclk <= 1'b0;
                            if (bit_idx != 5'd23) begin
                                bit_idx <= bit_idx + 5'd1;
                                adc_din <= cmd_bit((state == CONV_X) ? CMD_X : CMD_Y,
                                                   bit_idx + 5'd1);
                            end else if (state == CONV_X) begin
                                state   <= CONV_Y;
                                bit_idx <= '0;
                                x_tmp   <= shreg;
                                adc_din <= CMD_Y[7];
                            end else begin
                                state    <= HOLD;
                                cnt      <= SETTLE_LOAD;
                                bit_idx  <= '0;
                                x_reg    <= x_tmp;
                                y_reg    <= shreg;
                                adc_cs_n <= 1'b1;
                                adc_din  <= 1'b0;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (pen_down && continuous) begin
                        state    <= CONV_X;
                        div_cnt  <= '0;
                        bit_idx  <= '0;
                        adc_cs_n <= 1'b0;
                        adc_dclk <= 1'b0;
                        adc_din  <= CMD_X[7];
                    end else if (!pen_down) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign evt_set = {release_up, pen_edge, conv_done};
    assign evt_clr = evt_wr ? writedata[2:0] : 3'b000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable     <= 1'b0;
            continuous <= 1'b0;
            irq_mask   <= '0;
            evt        <= '0;
        end else begin
            if (ctrl_wr) begin
                enable     <= writedata[0];
                continuous <= writedata[1];
            end
            if (mask_wr) begin
                irq_mask <= writedata[2:0];
            end
            // Set is ORed in after the clear so a same-cycle set survives.
            evt <= (evt & ~evt_clr) | evt_set;
        end
    end

    assign irq = |(evt & irq_mask);

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux = {28'd0, busy, pen_down, continuous, enable};
            3'd1:    rd_mux = {20'd0, x_reg};
            3'd2:    rd_mux = {20'd0, y_reg};
            3'd3:    rd_mux = {29'd0, irq_mask};
            3'd4:    rd_mux = {29'd0, evt};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_touch_panel_scan_ctrl.sv
// Directed bench for touch_panel_scan_ctrl with a behavioural ADS7843-style serial model.
module tb_touch_panel_scan_ctrl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        pen_irq_n;
    logic        adc_cs_n;
    logic        adc_dclk;
    logic        adc_din;
    logic        adc_dout;

    int n_cmp;
    int n_err;

    logic [11:0] x_val;
    logic [11:0] y_val;

    // Monitor state, written only by the monitor process
    int          rise_cnt;
    int          csn_low_total;
    int          pair_total;
    int          unstable_total;
    logic [47:0] cap48;
    logic        din_hold;
    logic        prev_dclk;
    logic        prev_csn;

    touch_panel_scan_ctrl #(
        .CLK_DIV      (2),
        .SETTLE_CYCLES(4),
        .CMD_X        (8'h90),
        .CMD_Y        (8'hD0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .pen_irq_n (pen_irq_n),
        .adc_cs_n  (adc_cs_n),
        .adc_dclk  (adc_dclk),
        .adc_din   (adc_din),
        .adc_dout  (adc_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rise_cnt       = 0;
        csn_low_total  = 0;
        pair_total     = 0;
        unstable_total = 0;
        cap48          = '0;
        din_hold       = 1'b0;
        prev_dclk      = 1'b0;
        prev_csn       = 1'b1;
        adc_dout       = 1'b0;
    end

    // ADC model: shifts a result bit out after each falling DCLK 9..20 of a conversion.
    always @(negedge clk) begin
        int          k;
        logic [11:0] val;
        logic [11:0] sh;
        if (adc_cs_n !== 1'b0) begin
            rise_cnt = 0;
            adc_dout = 1'b0;
        end else begin
            csn_low_total = csn_low_total + 1;
            if (!prev_dclk && adc_dclk) begin
                rise_cnt = rise_cnt + 1;
                cap48    = {cap48[46:0], adc_din};
                din_hold = adc_din;
            end else if (adc_dclk && (adc_din !== din_hold)) begin
                unstable_total = unstable_total + 1;
            end
            if (prev_dclk && !adc_dclk) begin
                k   = ((rise_cnt - 1) % 24) + 1;
                val = (rise_cnt > 24) ? y_val : x_val;
                if (k >= 9 && k <= 20) begin
                    sh       = val >> (20 - k);
                    adc_dout = sh[0];
                end else begin
                    adc_dout = 1'b0;
                end
            end
        end
        if (prev_csn && (adc_cs_n === 1'b0)) pair_total = pair_total + 1;
        prev_dclk = adc_dclk;
        prev_csn  = adc_cs_n;
    end

    // Bus tasks are entered at a falling clock edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wait_csn(input logic level, input int limit);
        for (int i = 0; i < limit && (adc_cs_n !== level); i++) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        pen_irq_n  = 1'b1;
        x_val      = 12'h000;
        y_val      = 12'h000;
        repeat (3) @(negedge clk);
        n_cmp++; if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL rst_cs_n: got %b want 1", adc_cs_n); end
        n_cmp++; if (adc_dclk !== 1'b0) begin n_err++; $display("FAIL rst_dclk: got %b want 0", adc_dclk); end
        n_cmp++; if (adc_din !== 1'b0) begin n_err++; $display("FAIL rst_din: got %b want 0", adc_din); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
        n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL rst_readdata: got %h want 0", readdata); end
        reset_n = 1'b1;
        @(negedge clk);
        bus_write(3'd3, 32'h2);
        bus_write(3'd0, 32'h1);
        pen_irq_n = 1'b0;
        wait_csn(1'b0, 100);
        n_cmp++; if (adc_cs_n !== 1'b0) begin n_err++; $display("FAIL rst_conv_start: got cs_n=%b want 0", adc_cs_n); end
        repeat (5) @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL rst_irq_pre: got %b want 1", irq); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL rst_async_cs_n: got %b want 1", adc_cs_n); end
        n_cmp++; if (adc_dclk !== 1'b0) begin n_err++; $display("FAIL rst_async_dclk: got %b want 0", adc_dclk); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_async_irq: got %b want 0", irq); end
        pen_irq_n = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), d);
            n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_reg%0d: got %h want 0", a, d); end
        end
    endtask

    task automatic test_single_tap;
        logic [31:0] d;
        int csn_base;
        int unst_base;
        bus_write(3'd3, 32'h1);
        bus_write(3'd0, 32'h1);
        bus_write(3'd4, 32'h7);
        x_val     = 12'hABC;
        y_val     = 12'h123;
        csn_base  = csn_low_total;
        unst_base = unstable_total;
        pen_irq_n = 1'b0;
        wait_csn(1'b0, 100);
        wait_csn(1'b1, 400);
        n_cmp++; if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL tap_done: got cs_n=%b want 1", adc_cs_n); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL tap_irq: got %b want 1", irq); end
        n_cmp++; if (csn_low_total - csn_base != 192) begin n_err++; $display("FAIL tap_cs_low_len: got %0d want 192", csn_low_total - csn_base); end
        n_cmp++; if (cap48 !== 48'h90_0000_D0_0000) begin n_err++; $display("FAIL cmd_bits: got %h want 900000d00000", cap48); end
        n_cmp++; if (unstable_total != unst_base) begin n_err++; $display("FAIL cmd_din_stable: got %0d changes want 0", unstable_total - unst_base); end
        bus_read(3'd1, d);
        n_cmp++; if (d !== 32'hABC) begin n_err++; $display("FAIL tap_x: got %h want abc", d); end
        bus_read(3'd2, d);
        n_cmp++; if (d !== 32'h123) begin n_err++; $display("FAIL tap_y: got %h want 123", d); end
        bus_read(3'd4, d);
        n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL tap_event: got %h want 3", d); end
        bus_write(3'd4, 32'h1);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL tap_irq_clear: got %b want 0", irq); end
        pen_irq_n = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(3'd0, d);
        n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL tap_ctrl_idle: got %h want 1", d); end
        bus_read(3'd4, d);
        n_cmp++; if (d !== 32'h6) begin n_err++; $display("FAIL tap_pen_up: got %h want 6", d); end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        bus_write(3'd4, 32'h7);
        x_val     = 12'h5A5;
        y_val     = 12'hA5A;
        pen_irq_n = 1'b0;
        wait_csn(1'b0, 100);
        repeat (191) @(negedge clk);
        bus_write(3'd4, 32'h1);
        n_cmp++; if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL coll_align: got cs_n=%b want 1", adc_cs_n); end
        bus_read(3'd4, d);
        n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL coll_event: got %h want 3", d); end
        bus_read(3'd1, d);
        n_cmp++; if (d !== 32'h5A5) begin n_err++; $display("FAIL coll_x: got %h want 5a5", d); end
        bus_read(3'd2, d);
        n_cmp++; if (d !== 32'hA5A) begin n_err++; $display("FAIL coll_y: got %h want a5a", d); end
        pen_irq_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_abort;
        logic [31:0] d;
        bus_write(3'd4, 32'h7);
        x_val     = 12'h111;
        y_val     = 12'h222;
        pen_irq_n = 1'b0;
        wait_csn(1'b0, 100);
        repeat (100) @(negedge clk);
        bus_write(3'd0, 32'h0);
        n_cmp++; if (adc_cs_n !== 1'b1) begin n_err++; $display("FAIL abort_cs_n: got %b want 1", adc_cs_n); end
        n_cmp++; if (adc_dclk !== 1'b0) begin n_err++; $display("FAIL abort_dclk: got %b want 0", adc_dclk); end
        n_cmp++; if (adc_din !== 1'b0) begin n_err++; $display("FAIL abort_din: got %b want 0", adc_din); end
        bus_read(3'd0, d);
        n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL abort_ctrl: got %h want 4", d); end
        bus_read(3'd1, d);
        n_cmp++; if (d !== 32'h5A5) begin n_err++; $display("FAIL abort_x: got %h want 5a5", d); end
        bus_read(3'd2, d);
        n_cmp++; if (d !== 32'hA5A) begin n_err++; $display("FAIL abort_y: got %h want a5a", d); end
        bus_read(3'd4, d);
        n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL abort_event: got %h want 2", d); end
        pen_irq_n = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(3'd4, d);
        n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL abort_no_pen_up: got %h want 2", d); end
    endtask

    task automatic test_continuous;
        logic [31:0] d;
        int pair_base;
        int dr_seen;
        bus_write(3'd4, 32'h7);
        bus_write(3'd3, 32'h1);
        bus_write(3'd0, 32'h3);
        x_val     = 12'h321;
        y_val     = 12'h654;
        pair_base = pair_total;
        dr_seen   = 0;
        pen_irq_n = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_csn(1'b0, 300);
            if (p == 2) pen_irq_n = 1'b1;
            wait_csn(1'b1, 400);
            if (irq === 1'b1) dr_seen++;
            bus_write(3'd4, 32'h1);
        end
        repeat (30) @(negedge clk);
        n_cmp++; if (dr_seen != 3) begin n_err++; $display("FAIL cont_data_ready: got %0d want 3", dr_seen); end
        n_cmp++; if (pair_total - pair_base != 3) begin n_err++; $display("FAIL cont_pairs: got %0d want 3", pair_total - pair_base); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL cont_irq: got %b want 0", irq); end
        bus_read(3'd0, d);
        n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL cont_ctrl: got %h want 3", d); end
        bus_read(3'd4, d);
        n_cmp++; if (d !== 32'h6) begin n_err++; $display("FAIL cont_event: got %h want 6", d); end
        bus_read(3'd1, d);
        n_cmp++; if (d !== 32'h321) begin n_err++; $display("FAIL cont_x: got %h want 321", d); end
        bus_read(3'd2, d);
        n_cmp++; if (d !== 32'h654) begin n_err++; $display("FAIL cont_y: got %h want 654", d); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_tap();
        test_collision();
        test_abort();
        test_continuous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/touch_panel_scan_ctrl.md
Name: touch_panel_scan_ctrl

Overview:
- Avalon-MM slave controller for a 4-wire resistive touch ADC (ADS7843-class, 3-wire serial + PENIRQ).
- On pen-down, runs an X then Y 12-bit conversion over the serial link and publishes both results atomically.
- Raises a maskable IRQ on new data and on pen events; replaces raw software polling of the pen_irq_n PIO.
- Sits on the SOPC system bus beside the touch panel PIO, on the same clock.

Parameters:
- CLK_DIV, 16, clk cycles per DCLK half-period (>=1).
- SETTLE_CYCLES, 5000, clk cycles waited after pen-down before, and between, conversion pairs (>=1).
- CMD_X, 8'h90, command byte for the X conversion.
- CMD_Y, 8'hD0, command byte for the Y conversion.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset: asynchronous assert, active-low; one clock; all flops async-reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data, valid 1 cycle after address.
- irq  out  1  interrupt, level, active-high.
- pen_irq_n  in  1  PENIRQ from ADC, asynchronous, low = touched.
- adc_cs_n  out  1  ADC chip select, active-low.
- adc_dclk  out  1  ADC serial clock.
- adc_din  out  1  command bits to ADC.
- adc_dout  in  1  result bits from ADC.

Behaviour:
- Reset values: readdata=0, irq=0, adc_cs_n=1, adc_dclk=0, adc_din=0; all registers 0; FSM=IDLE.
- pen_irq_n passes a 2-flop synchronizer; pen_down = ~sync2. A falling edge of the synchronized input is a pen-down edge.
- Register map (read mux zero-extended; readdata updates every cycle):
  - 0 CTRL: b0 enable (RW), b1 continuous (RW), b2 pen_down (RO), b3 busy (RO, FSM != IDLE).
  - 1 X: [11:0] RO.
  - 2 Y: [11:0] RO.
  - 3 IRQ_MASK: [2:0] RW.
  - 4 EVENT: b0 data_ready, b1 pen_down_edge, b2 pen_up; write-1-to-clear.
  - 5-7: read 0.
- irq = |(EVENT & IRQ_MASK).
- A set and a W1C clear on the same bit in the same cycle: set wins.
- pen_down_edge event is set on every synchronized falling edge, regardless of enable.
- FSM states: IDLE, SETTLE, CONV_X, CONV_Y, HOLD.
  - IDLE: if enable && pen_down, go to SETTLE and load the counter with SETTLE_CYCLES.
  - SETTLE: count down to 0, then go to CONV_X. pen_irq_n is ignored.
  - CONV_X / CONV_Y: 24 DCLK periods each, back-to-back. adc_cs_n is low from the first cycle of CONV_X through the last cycle of CONV_Y.
  - DCLK phasing: low for CLK_DIV clks, then high for CLK_DIV clks.
  - adc_din drives command bit 7..0 MSB-first, changing at period starts (DCLK low); it is 0 for periods 9-24.
  - adc_dout is sampled on each rising DCLK. Rising edges 10..21 (1-based) give D11..D0; other samples are discarded.
  - Each conversion takes 48*CLK_DIV clks, so adc_cs_n is low for exactly 96*CLK_DIV clks.
  - End of CONV_Y: X and Y registers update in the same cycle, data_ready is set, adc_cs_n goes to 1, adc_dclk=0, and the FSM enters HOLD with the counter loaded to SETTLE_CYCLES.
  - HOLD: pen_irq_n is ignored until the counter reaches 0. Then:
    - pen_down && continuous && enable: go to CONV_X.
    - !pen_down: set pen_up, go to IDLE.
    - otherwise: stay in HOLD until pen released (then set pen_up, go to IDLE) or enable cleared (go to IDLE, no pen_up).
- enable cleared in any non-IDLE state: next cycle IDLE, adc_cs_n=1, adc_dclk=0, adc_din=0; X/Y unchanged; no events set.
- Async reset mid-transfer: outputs return to reset values immediately; no partial result is published.

Test Plan:
- Reset: assert reset_n=0 mid-CONV_X -> adc_cs_n=1, adc_dclk=0, irq=0 within the same cycle; all register reads return 0 after release.
- Single tap, CLK_DIV=2, SETTLE_CYCLES=4, enable=1, mask=3'b001, ADC model returns X=12'hABC, Y=12'h123, pen held -> adc_cs_n low exactly 192 clks; reg1=0xABC, reg2=0x123, EVENT b0=1, irq=1; write 1 to EVENT -> irq=0 next cycle.
- Command check: capture adc_din on rising DCLK -> 8'h90 followed by 16 zeros, then 8'hD0 followed by 16 zeros; adc_din is stable while DCLK is high.
- Set/clear collision: W1C write of EVENT b0 in the same cycle as end of CONV_Y -> b0 remains 1.
- Abort: clear enable during CONV_Y -> next cycle adc_cs_n=1, busy=0; X/Y keep their old values; data_ready is not set.
- Continuous: continuous=1, pen held for 3 pairs then released -> data_ready is set 3 times; pen_up set after HOLD expires; FSM returns to IDLE with busy=0.
